key_debouncer: RTL and testbench

Conditions the raw push-button pins before they reach the key PIO slave's in_port. Each key passes through a 2-FF synchronizer and a per-key debounce state machine. key_clean is the stable, glitch-free level that drives the PIO. It keeps the board's raw polarity, so software reads the same values as before. One-cycle press and release pulses are also provided for fabric logic such as game input FSMs.

---
 rtl/key_debounce_pkg.sv | 24 ++
 rtl/key_debounce_bit.sv | 146 ++++++++++++++
 rtl/key_debouncer.sv | 44 ++++
 tb/tb_key_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pkg
// Brief    : Shared types, default timing constants and polarity helper for
//            the push-button debouncer.
// Revision : 1.0
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_bit
// Brief    : One key: 2-FF synchronizer, debounce FSM, press/release pulses,
//            auto-repeat when KEY_REPEAT_EN is defined.
// Revision : 1.0
// ============================================================================
module key_debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_clean,
    output logic key_press,
    output logic key_release
);

    localparam int       c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic     c_RELEASED = released_level(ACTIVE_LOW != 0);
    localparam logic     c_PRESSED  = ~c_RELEASED;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_clean;
    logic               r_press;
    logic               r_release;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;

    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_differs;
    logic               w_accept;
    logic               w_to_pressed;
    logic               w_press_nxt;
    logic               w_release_nxt;
    logic               w_rpt_fire;

    assign w_differs = (r_sync2 != r_clean);

    // State register, plus the registered level/pulse outputs it governs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= c_RELEASED;
            r_sync2   <= c_RELEASED;
            r_clean   <= c_RELEASED;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_accept) begin
                r_clean <= r_sync2;
            end
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state: any reversion while checking restarts from scratch
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_STABLE: begin
                if (w_differs) begin
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (!w_differs || (r_cnt == c_CNT_MAX)) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_accept      = (r_state == ST_CHECK) && w_differs && (r_cnt == c_CNT_MAX);
        w_to_pressed  = (r_sync2 == c_PRESSED);
        w_press_nxt   = (w_accept && w_to_pressed) || w_rpt_fire;
        w_release_nxt = w_accept && !w_to_pressed;
    end

`ifdef KEY_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_M1  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_M1 = c_RPT_W'(REPEAT_PERIOD - 1);

    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_rpt_first;
    logic               w_held;

    // While pressed, an accept can only be the release edge, which must not repeat
    assign w_held     = (r_clean == c_PRESSED) && !w_accept;
    assign w_rpt_fire = w_held &&
                        (r_rpt_cnt == (r_rpt_first ? c_DELAY_M1 : c_PERIOD_M1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (!w_held) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end
`else
    logic w_rpt_unused;
    assign w_rpt_unused = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
    assign w_rpt_fire   = 1'b0;
`endif

    assign key_clean   = r_clean;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Brief    : WIDTH independent push-button debouncers feeding the key PIO.
//            Define KEY_REPEAT_EN to add auto-repeat press pulses.
// Revision : 1.0
// ============================================================================
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_key
            key_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_bit (
                .clk         (clk),
                .reset_n     (reset_n),
                .key_raw     (key_raw[i]),
                .key_clean   (key_clean[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debouncer
// Brief    : Scoreboard bench for key_debouncer (WIDTH=2, 4-cycle debounce).
// Revision : 1.0
// ============================================================================
module tb_key_debouncer;

    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] key_raw = 2'b11;
    logic [1:0] key_clean;
    logic [1:0] key_press;
    logic [1:0] key_release;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] clean;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    key_debouncer #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_clean   (key_clean),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void push(input int c, input logic [1:0] p, input logic [1:0] r,
                                 input logic [1:0] cl);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.clean = cl;
        sb.push_back(e);
    endfunction

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse cycle must match the next scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (key_press !== 2'b00 || key_release !== 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc %0d press %b release %b clean %b",
                         cyc, key_press, key_release, key_clean);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release ||
                    e.clean !== key_clean) begin
                    errors++;
                    $display("FAIL pulse: got cyc %0d press %b release %b clean %b, expected cyc %0d press %b release %b clean %b",
                             cyc, key_press, key_release, key_clean, e.cyc, e.press, e.rel, e.clean);
                end
            end
        end
    end

    // Press key (optionally after a 0,1 bounce), hold, release; expectations queued up front
    task automatic tap(input int key, input int hold, input bit bounce);
        int         k;
        int         t;
        logic [1:0] pm;
        logic [1:0] cm;
        pm = 2'b00; pm[key] = 1'b1;
        cm = 2'b11; cm[key] = 1'b0;
        if (bounce) begin
            @(negedge clk) key_raw[key] = 1'b0;
            @(negedge clk) key_raw[key] = 1'b1;
        end
        @(negedge clk);
        k = cyc;
        push(k + 7, pm, 2'b00, cm);
`ifdef KEY_REPEAT_EN
        t = k + 7 + RD;
        while (t < k + hold + 7) begin
            push(t, pm, 2'b00, cm);
            t += RP;
        end
`else
        t = 0;
`endif
        push(k + hold + 7, 2'b00, pm, 2'b11);
        key_raw[key] = 1'b0;
        repeat (6) @(negedge clk);
        check2("pre_accept_clean", key_clean, 2'b11);
        repeat (hold - 6) @(negedge clk);
        key_raw[key] = 1'b1;
        repeat (6) @(negedge clk);
        check2("pre_release_clean", key_clean, cm);
        repeat (8) @(negedge clk);
        check2("after_release_clean", key_clean, 2'b11);
    endtask

    initial begin
        int m;
        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check2("reset_clean", key_clean, 2'b11);
        check2("reset_press", key_press, 2'b00);
        check2("reset_release", key_release, 2'b00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press/hold/release of key 0 (long hold exercises repeat if enabled)
        tap(0, 25, 1'b0);

        // 3-cycle glitch must never be accepted
        @(negedge clk) key_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        check2("glitch_clean", key_clean, 2'b11);

        // Bouncing key 1
        tap(1, 10, 1'b1);

        // Reset mid-count, then a held key needs a full debounce after deassertion
        @(negedge clk) key_raw[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check2("rst_midcount_clean", key_clean, 2'b11);
        repeat (3) @(negedge clk);
        m = cyc;
        push(m + 7, 2'b01, 2'b00, 2'b10);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check2("post_reset_pre_accept", key_clean, 2'b11);
        repeat (3) @(negedge clk);
        check2("held_after_reset", key_clean, 2'b10);

        // Asynchronous reset while accepted: outputs return without a clock edge
        #2 reset_n = 1'b0;
        #1 check2("rst_async_clean", key_clean, 2'b11);
        check2("rst_async_press", key_press, 2'b00);
        key_raw[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check2("final_clean", key_clean, 2'b11);

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: got none, expected cyc %0d press %b release %b",
                     e.cyc, e.press, e.rel);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
